// File: rtl/pulse_feeder_if.sv
// Burst request / pulse output bundle between a requester and pulse_feeder.
interface pulse_feeder_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             hold;
  logic             out;
  logic [WIDTH-1:0] total;
  logic             busy;
  logic             full;
  logic             dropped;

  modport master (
    output req_valid, req_len, hold,
    input  req_ready, out, total, busy, full, dropped
  );

  modport slave (
    input  req_valid, req_len, hold,
    output req_ready, out, total, busy, full, dropped
  );
endinterface

// File: rtl/pulse_feeder.sv
// Issues bursts of single-cycle increment pulses, capping the lifetime total at LIMIT.
module pulse_feeder #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 9,
  parameter int LEN_W = 4
) (
  input logic             clk,
  input logic             rst,
  pulse_feeder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BURST, FULL} state_t;

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  state_t             state, state_n;
  logic [LEN_W-1:0]   remaining, remaining_n;
  logic [WIDTH-1:0]   total, total_n;
  logic               dropped, dropped_n;
  logic               issue;
  logic [WIDTH-1:0]   total_inc;
  logic [LEN_W-1:0]   rem_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      total     <= '0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      total     <= total_n;
      dropped   <= dropped_n;
    end
  end

  assign issue     = (state == BURST) && !bus.hold;
  assign total_inc = total + 1'b1;
  assign rem_dec   = remaining - 1'b1;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    total_n     = total;
    dropped_n   = dropped;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && (bus.req_len != '0)) begin
          remaining_n = bus.req_len;
          state_n     = BURST;
        end
      end
      BURST: begin
        if (issue) begin
          total_n     = total_inc;
          remaining_n = rem_dec;
          // Reaching LIMIT takes priority over finishing the burst.
          if (total_inc == LIM) begin
            state_n = FULL;
            if (rem_dec != '0) dropped_n = 1'b1;
          end else if (rem_dec == '0) begin
            state_n = IDLE;
          end
        end
      end
      FULL: begin
        state_n = FULL;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.out       = issue;
  assign bus.total     = total;
  assign bus.busy      = (state == BURST);
  assign bus.full      = (state == FULL);
  assign bus.dropped   = dropped;

endmodule
